// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 serial receiver with a one-entry valid/ready output buffer.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   rx         asynchronous serial input, idles high
//   data       received byte, meaningful while valid = 1
//   valid      a byte is held in the output buffer
//   ready      consumer accepts the byte (transfer on valid && ready)
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   overrun    sticky: a completed byte was dropped because the buffer was full
//   busy       receiver is anywhere but IDLE
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit;
    logic [7:0]             r_shift;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   r_busy;

    logic w_rx_s;
    logic w_handshake;

    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_handshake = r_valid & ready;

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

    // Metastability synchronizer for the asynchronous rx pin; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{1'b1}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    // Receive FSM plus output buffer; busy is registered alongside every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= CNT_ZERO;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            // A handshake empties the buffer and clears overrun; a completion
            // on the same edge overrides valid below and reloads it.
            if (w_handshake) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= CNT_ZERO;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                // Wait half a bit, then re-check the line to reject glitches.
                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= CNT_ZERO;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                            r_bit   <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                // LSB arrives first: shifting in from the top leaves bit 0 in r_shift[0].
                S_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= CNT_ZERO;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt <= CNT_ZERO;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (!r_valid || w_handshake) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                // Hold off through a break so it reports only one frame error.
                S_WAIT_IDLE: begin
                    r_cnt <= CNT_ZERO;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the SoC UART pin `urx`.
- Converts 8N1 frames into bytes and presents them through a one-entry valid/ready buffer to the MMIO/peripheral logic.
- It is the receive-side counterpart to the core's UART transmitter on `utx`.
- A bench transmitter model drives `urx` at the top level.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per bit period (100 MHz / 115200). Legal values are 4 or more.
- SYNC_STAGES, 2: number of metastability flops on the `rx` input. Legal values are 2 or more.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- data  out  8  received byte; valid only while `valid` = 1.
- valid  out  1  a byte is held in the output buffer.
- ready  in  1  consumer accepts the byte; transfer occurs when `valid` && `ready` at a rising edge.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- overrun  out  1  sticky flag: a completed byte was dropped because the buffer was full.
- busy  out  1  1 in every state except IDLE.

Behaviour:

Reset:
- The synchronizer flops reset to 1.
- State goes to IDLE; bit counter and sample counter go to 0.
- Outputs reset to: data = 0x00, valid = 0, frame_err = 0, overrun = 0, busy = 0.
- Reset mid-frame abandons the frame and discards the partial shift register. No valid or error is raised.

Synchronizer and timing:
- `rx_s` is `rx` after SYNC_STAGES flops. All decisions use `rx_s`.
- The sample counter is `$clog2(CLKS_PER_BIT)` bits wide.
- HALF = CLKS_PER_BIT / 2, using integer division.

State machine (IDLE, START, DATA, STOP, WAIT_IDLE):
- IDLE: if `rx_s` = 0, go to START with cnt = 0.
- START: count to HALF-1.
  - At cnt = HALF-1, resample `rx_s`.
  - If 1, this is a false start: return to IDLE.
  - If 0, go to DATA with cnt = 0 and bit = 0.
- DATA: at cnt = CLKS_PER_BIT-1, shift `rx_s` into bit[bit], LSB first, and reset cnt.
  - After bit 7, go to STOP.
- STOP: at cnt = CLKS_PER_BIT-1, sample `rx_s`.
  - If 1: this is a completion event; go to IDLE.
  - If 0: pulse frame_err high for exactly 1 cycle, drop the byte, and go to WAIT_IDLE.
- WAIT_IDLE: remain until `rx_s` = 1, then go to IDLE. This means a break condition produces only one frame_err.

Output buffer on a completion event at edge N:
- If the buffer is empty, or `valid` && `ready` at edge N: `data` is loaded and `valid` = 1 after edge N. No overrun.
- Otherwise, `data` is unchanged, the new byte is lost, and `overrun` is set to 1.
- Consumption without a completion event clears `valid` at the edge.
- `data` holds its last value after consumption.
- `overrun` clears only on a successful `valid` && `ready` handshake or on rst.
  - If an overrun event and a handshake occur on the same edge, the handshake takes priority: the new byte is loaded and overrun is not set.

Latency:
- `valid` rises 1 cycle after the stop-bit mid-sample edge.
- The stop-bit mid-sample edge is (SYNC_STAGES + HALF + 9·CLKS_PER_BIT) cycles after the falling edge on `rx`, ±1 cycle due to synchronizer phase.

Other boundary conditions:
- `ready` asserted while `valid` = 0 has no effect.
- A back-to-back frame (next start bit immediately after the stop mid-sample) must be received. IDLE detects the low level on the next cycle.

Test Plan (CLKS_PER_BIT = 8, SYNC_STAGES = 2):
1. Send 0xA5 as an 8N1 frame with `ready` held 0 → data = 0xA5, valid = 1 about 78±1 cycles after the start edge, frame_err = 0, overrun = 0. Then pulse `ready` for 1 cycle → valid = 0 on the next cycle.
2. Drive `rx` low for 3 cycles, then high (glitch) → state returns to IDLE, no valid, no frame_err, busy drops within 8 cycles.
3. Send 0x3C with the stop bit driven 0 for 20 bit times, then high → exactly one frame_err pulse, valid stays 0, busy = 1 until `rx` returns high.
4. Send 0x11 then 0x22 back-to-back with `ready` = 0 → data = 0x11, overrun = 1. Then assert `ready` → valid = 0, overrun = 0. Repeat with `ready` = 1 held throughout → both bytes are delivered and overrun stays 0.
5. Assert rst during bit 4 of a frame, then send 0x5A → all outputs are 0 during reset, the partial frame is discarded, 0x5A is received correctly and no frame_err occurs.
6. Send 0x00 and then 0xFF at ±3% baud skew → both bytes are received exactly.
